// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder sequencer: FSM state encoding and counter sizing.
package serial_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit counter width: enough to reach WIDTH-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between a requester and the bit-serial adder.
// The optional `sub` request bit exists only when SERIAL_ADD_SUB_EN is defined.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin_init;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, op_a, op_b, cin_init, sub,
                  input  busy, done, result, cout);
  modport slave  (input  start, op_a, op_b, cin_init, sub,
                  output busy, done, result, cout);
`else
  modport master (output start, op_a, op_b, cin_init,
                  input  busy, done, result, cout);
  modport slave  (input  start, op_a, op_b, cin_init,
                  output busy, done, result, cout);
`endif

endinterface

// File: rtl/all_adder.sv
// One-bit full-adder cell: sum and carry-out (count) of three input bits.
module all_adder (
  input  logic in_1,
  input  logic in_2,
  input  logic cin,
  output logic sum,
  output logic count
);

  assign sum   = in_1 ^ in_2 ^ cin;
  assign count = (in_1 & in_2) | (cin & (in_1 ^ in_2));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: LSB-first, one bit per clock through a single full-adder cell.
// Optional subtract mode is built in when SERIAL_ADD_SUB_EN is defined.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  serial_add_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e           state_q,  state_d;
  logic [WIDTH-1:0] a_sr_q,   a_sr_d;
  logic [WIDTH-1:0] b_sr_q,   b_sr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             carry_q,  carry_d;
  logic             cout_q,   cout_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic             sum_c;
  logic             count_c;
  logic             last_c;
  logic [WIDTH:0]   res_ext_c;
  logic [WIDTH-1:0] b_load_c;
  logic             carry_load_c;

  // Subtraction is A + ~B + 1; the adder datapath is shared.
`ifdef SERIAL_ADD_SUB_EN
  assign b_load_c     = bus.sub ? ~bus.op_b : bus.op_b;
  assign carry_load_c = bus.sub ? 1'b1 : bus.cin_init;
`else
  assign b_load_c     = bus.op_b;
  assign carry_load_c = bus.cin_init;
`endif

  all_adder u_fa (
    .in_1  (a_sr_q[0]),
    .in_2  (b_sr_q[0]),
    .cin   (carry_q),
    .sum   (sum_c),
    .count (count_c)
  );

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    result_d  = result_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    res_ext_c = {sum_c, result_q};
    last_c    = (cnt_q == CNT_W'(WIDTH - 1));

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.op_a;
          b_sr_d  = b_load_c;
          carry_d = carry_load_c;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        result_d = res_ext_c[WIDTH:1];
        carry_d  = count_c;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_c) begin
          cout_d  = count_c;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: directed table and corner sequences at WIDTH=8, plus a random
// scoreboard run on WIDTH=1, 8 and 32 instances in lockstep. Honours SERIAL_ADD_SUB_EN.
module tb_serial_add_ctrl;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_res;
    logic       exp_cout;
  } vec_t;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  int   n_vec     = 0;
  int   n_err     = 0;

  always #5 sys_clk = ~sys_clk;

  serial_add_ctrl_if #(.WIDTH(1))  bus1 ();
  serial_add_ctrl_if #(.WIDTH(8))  bus8 ();
  serial_add_ctrl_if #(.WIDTH(32)) bus32 ();

  serial_add_ctrl #(.WIDTH(1))  dut1  (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus1));
  serial_add_ctrl #(.WIDTH(8))  dut8  (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus8));
  serial_add_ctrl #(.WIDTH(32)) dut32 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus32));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {cout,result} from plain integer arithmetic on a w-bit word.
  function automatic logic [32:0] ref_add(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sub);
    longint unsigned m, s;
    m = (64'd1 << w) - 64'd1;
    if (sub) s = (64'(a) & m) + (64'(~b) & m) + 64'd1;
    else     s = (64'(a) & m) + (64'(b) & m) + 64'(cin);
    return 33'(s & ((m << 1) | 64'd1));
  endfunction

  task automatic drive_idle();
    bus1.start = 1'b0;  bus1.op_a = '0;  bus1.op_b = '0;  bus1.cin_init = 1'b0;
    bus8.start = 1'b0;  bus8.op_a = '0;  bus8.op_b = '0;  bus8.cin_init = 1'b0;
    bus32.start = 1'b0; bus32.op_a = '0; bus32.op_b = '0; bus32.cin_init = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    bus1.sub = 1'b0; bus8.sub = 1'b0; bus32.sub = 1'b0;
`endif
  endtask

  // One WIDTH=8 operation with a single-cycle start pulse; reports latency and pulse counts.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      output logic [7:0] res, output logic co,
                      output int lat, output int busy_n, output int done_n);
    lat = 0; busy_n = 0; done_n = 0; res = '0; co = 1'b0;
    bus8.op_a = a; bus8.op_b = b; bus8.cin_init = cin; bus8.start = 1'b1;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge sys_clk);
      if (cyc == 1) bus8.start = 1'b0;
      if (bus8.busy) busy_n++;
      if (bus8.done) begin
        done_n++;
        if (lat == 0) begin
          lat = cyc; res = bus8.result; co = bus8.cout;
        end
      end
    end
  endtask

  // Same operands to all three widths at once, checked against the reference model.
  task automatic run_all(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic sub);
    int          lat [3];
    int          dn  [3];
    logic [32:0] got [3];
    int          w   [3];
    w[0] = 1; w[1] = 8; w[2] = 32;
    for (int i = 0; i < 3; i++) begin lat[i] = 0; dn[i] = 0; got[i] = '0; end
    bus1.op_a  = 1'(a);  bus1.op_b  = 1'(b);  bus1.cin_init  = cin;
    bus8.op_a  = 8'(a);  bus8.op_b  = 8'(b);  bus8.cin_init  = cin;
    bus32.op_a = a;      bus32.op_b = b;      bus32.cin_init = cin;
`ifdef SERIAL_ADD_SUB_EN
    bus1.sub = sub; bus8.sub = sub; bus32.sub = sub;
`endif
    bus1.start = 1'b1; bus8.start = 1'b1; bus32.start = 1'b1;
    for (int cyc = 1; cyc <= 36; cyc++) begin
      @(negedge sys_clk);
      if (cyc == 1) begin bus1.start = 1'b0; bus8.start = 1'b0; bus32.start = 1'b0; end
      if (bus1.done)  begin dn[0]++; if (lat[0] == 0) begin lat[0] = cyc; got[0] = 33'({bus1.cout, bus1.result}); end end
      if (bus8.done)  begin dn[1]++; if (lat[1] == 0) begin lat[1] = cyc; got[1] = 33'({bus8.cout, bus8.result}); end end
      if (bus32.done) begin dn[2]++; if (lat[2] == 0) begin lat[2] = cyc; got[2] = 33'({bus32.cout, bus32.result}); end end
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rand_w%0d_sum a=%0h b=%0h cin=%0b sub=%0b", w[i], a, b, cin, sub),
          64'(got[i]), 64'(ref_add(w[i], a, b, cin, sub)));
      chk($sformatf("rand_w%0d_latency", w[i]), 64'(lat[i]), 64'(w[i] + 1));
      chk($sformatf("rand_w%0d_done_count", w[i]), 64'(dn[i]), 64'd1);
    end
  endtask

  initial begin
    vec_t        tbl [7];
    logic [7:0]  r;
    logic        c;
    int          lat, bn, dn, d1, d2, b10, b11;
    logic [8:0]  r1, r2;
    logic        rsub;

    tbl[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

    drive_idle();
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("reset_busy",   64'(bus8.busy),   64'd0);
    chk("reset_done",   64'(bus8.done),   64'd0);
    chk("reset_result", 64'(bus8.result), 64'd0);
    chk("reset_cout",   64'(bus8.cout),   64'd0);
    chk("reset_busy_w1_w32", 64'({bus1.busy, bus32.busy}), 64'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Directed table at WIDTH=8
    foreach (tbl[i]) begin
      run8(tbl[i].a, tbl[i].b, tbl[i].cin, r, c, lat, bn, dn);
      chk($sformatf("vec%0d_result", i), 64'(r), 64'(tbl[i].exp_res));
      chk($sformatf("vec%0d_cout", i), 64'(c), 64'(tbl[i].exp_cout));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd9);
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bn), 64'd9);
      chk($sformatf("vec%0d_done_count", i), 64'(dn), 64'd1);
    end

    // start held high, operands changed mid-run: one done per op, re-accept on first IDLE cycle
    d1 = 0; d2 = 0; dn = 0; b10 = -1; b11 = -1; r1 = '0; r2 = '0;
    bus8.op_a = 8'h12; bus8.op_b = 8'h34; bus8.cin_init = 1'b0; bus8.start = 1'b1;
    for (int cyc = 1; cyc <= 21; cyc++) begin
      @(negedge sys_clk);
      if (cyc == 3) begin bus8.op_a = 8'hFF; bus8.op_b = 8'h00; end
      if (bus8.done) begin
        if (dn == 0)      begin d1 = cyc; r1 = {bus8.cout, bus8.result}; end
        else if (dn == 1) begin d2 = cyc; r2 = {bus8.cout, bus8.result}; end
        dn++;
      end
      if (cyc == 10) b10 = int'(bus8.busy);
      if (cyc == 11) begin b11 = int'(bus8.busy); bus8.start = 1'b0; end
    end
    chk("hold_first_done_cycle", 64'(d1), 64'd9);
    chk("hold_first_sum", 64'(r1), 64'h046);
    chk("hold_idle_gap_busy", 64'(b10), 64'd0);
    chk("hold_reaccept_busy", 64'(b11), 64'd1);
    chk("hold_second_done_cycle", 64'(d2), 64'd19);
    chk("hold_second_sum", 64'(r2), 64'h0FF);
    chk("hold_done_count", 64'(dn), 64'd2);

    // Reset during RUN aborts without a done pulse
    dn = 0;
    bus8.op_a = 8'h5A; bus8.op_b = 8'h33; bus8.cin_init = 1'b1; bus8.start = 1'b1;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge sys_clk);
      if (cyc == 1) bus8.start = 1'b0;
      if (bus8.done) dn++;
      if (cyc == 4) sys_rst_n = 1'b0;
      if (cyc == 5) begin
        chk("abort_busy",   64'(bus8.busy),   64'd0);
        chk("abort_result", 64'(bus8.result), 64'd0);
        chk("abort_cout",   64'(bus8.cout),   64'd0);
        sys_rst_n = 1'b1;
      end
      if (cyc == 16) chk("abort_idle_after", 64'(bus8.busy), 64'd0);
    end
    chk("abort_no_done", 64'(dn), 64'd0);

`ifdef SERIAL_ADD_SUB_EN
    bus8.sub = 1'b1;
    run8(8'h10, 8'h01, 1'b0, r, c, lat, bn, dn);
    chk("sub_10_01_result", 64'(r), 64'h0F);
    chk("sub_10_01_cout", 64'(c), 64'd1);
    run8(8'h01, 8'h02, 1'b1, r, c, lat, bn, dn);
    chk("sub_01_02_result", 64'(r), 64'hFF);
    chk("sub_01_02_cout", 64'(c), 64'd0);
    bus8.sub = 1'b0;
`endif

    // Corner operands then random operands across all widths
    run_all(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    run_all(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_all(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0);
    for (int k = 0; k < 1000; k++) begin
`ifdef SERIAL_ADD_SUB_EN
      rsub = 1'($urandom_range(0, 1));
`else
      rsub = 1'b0;
`endif
      run_all($urandom, $urandom, 1'($urandom_range(0, 1)), rsub);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
